// File: rtl/alu_sequencer_if.sv
// Byte-stream, ALU operand and result signals of the ALU sequencer.
// The slave modport is the sequencer's view; master is the producer, ALU and consumer side.
interface alu_sequencer_if #(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned NB_OP   = 6
);
  logic [NB_DATA-1:0] i_data;
  logic               i_valid;
  logic               o_ready;
  logic [NB_DATA-1:0] o_alu_a;
  logic [NB_DATA-1:0] o_alu_b;
  logic [NB_OP-1:0]   o_alu_op;
  logic [NB_DATA-1:0] i_alu_result;
  logic [NB_DATA-1:0] o_result;
  logic               o_result_valid;
  logic               i_result_ack;
  logic               o_error;

  modport slave (
    input  i_data, i_valid, i_alu_result, i_result_ack,
    output o_ready, o_alu_a, o_alu_b, o_alu_op, o_result, o_result_valid, o_error
  );

  modport master (
    output i_data, i_valid, i_alu_result, i_result_ack,
    input  o_ready, o_alu_a, o_alu_b, o_alu_op, o_result, o_result_valid, o_error
  );
endinterface

// File: rtl/alu_sequencer.sv
// Collects A, B and op bytes from a valid/ready stream, presents them to an external ALU,
// captures the result and holds it until acknowledged; stalls mid-transaction time out.
module alu_sequencer #(
  parameter int unsigned NB_DATA = 8,
  parameter int unsigned NB_OP   = 6,
  parameter int unsigned TIMEOUT = 255
) (
  input logic           i_clock,
  input logic           i_reset,
  alu_sequencer_if.slave seq_bus
);

  localparam int unsigned CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] IDLE_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'((TIMEOUT < 1) ? 0 : TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_OP   = 3'd2,
    S_EXEC = 3'd3,
    S_HOLD = 3'd4
  } state_e;

  state_e             state_q;
  logic [NB_DATA-1:0] a_q;
  logic [NB_DATA-1:0] b_q;
  logic [NB_OP-1:0]   op_q;
  logic [NB_DATA-1:0] result_q;
  logic               result_valid_q;
  logic               ready_q;
  logic               error_q;
  logic [CNT_W-1:0]   idle_q;

  logic [NB_DATA-1:0] data_in;
  logic               xfer;
  logic               timeout_hit;
  logic [CNT_W-1:0]   idle_inc;

  assign data_in = seq_bus.i_data;

  always_comb begin
    xfer        = seq_bus.i_valid & ready_q;
    // Fires on the edge that would bring the counter up to TIMEOUT.
    timeout_hit = (idle_q >= IDLE_LAST);
    idle_inc    = (idle_q == IDLE_MAX) ? idle_q : idle_q + CNT_W'(1);
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q        <= S_A;
      a_q            <= '0;
      b_q            <= '0;
      op_q           <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      ready_q        <= 1'b1;
      error_q        <= 1'b0;
      idle_q         <= '0;
    end else begin
      error_q <= 1'b0;
      unique case (state_q)
        S_A: begin
          idle_q <= '0;
          if (xfer) begin
            a_q     <= data_in;
            state_q <= S_B;
          end
        end
        S_B: begin
          if (xfer) begin
            b_q     <= data_in;
            idle_q  <= '0;
            state_q <= S_OP;
          end else if (timeout_hit) begin
            idle_q  <= '0;
            error_q <= 1'b1;
            state_q <= S_A;
          end else begin
            idle_q <= idle_inc;
          end
        end
        S_OP: begin
          if (xfer) begin
            op_q    <= data_in[NB_OP-1:0];
            idle_q  <= '0;
            ready_q <= 1'b0;
            state_q <= S_EXEC;
          end else if (timeout_hit) begin
            idle_q  <= '0;
            error_q <= 1'b1;
            state_q <= S_A;
          end else begin
            idle_q <= idle_inc;
          end
        end
        S_EXEC: begin
          result_q       <= seq_bus.i_alu_result;
          result_valid_q <= 1'b1;
          state_q        <= S_HOLD;
        end
        S_HOLD: begin
          if (seq_bus.i_result_ack) begin
            result_valid_q <= 1'b0;
            ready_q        <= 1'b1;
            state_q        <= S_A;
          end
        end
        default: begin
          idle_q         <= '0;
          result_valid_q <= 1'b0;
          ready_q        <= 1'b1;
          state_q        <= S_A;
        end
      endcase
    end
  end

  assign seq_bus.o_ready        = ready_q;
  assign seq_bus.o_alu_a        = a_q;
  assign seq_bus.o_alu_b        = b_q;
  assign seq_bus.o_alu_op       = op_q;
  assign seq_bus.o_result       = result_q;
  assign seq_bus.o_result_valid = result_valid_q;
  assign seq_bus.o_error        = error_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer (TIMEOUT=4) with a small behavioural ALU:
// op 0x20 adds, any other op XORs.
module tb_alu_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  alu_sequencer_if #(.NB_DATA(8), .NB_OP(6)) seq_bus ();

  alu_sequencer #(
    .NB_DATA(8),
    .NB_OP  (6),
    .TIMEOUT(4)
  ) dut (
    .i_clock(clk),
    .i_reset(rst),
    .seq_bus(seq_bus)
  );

  assign seq_bus.i_alu_result = (seq_bus.o_alu_op == 6'h20) ?
                                (seq_bus.o_alu_a + seq_bus.o_alu_b) :
                                (seq_bus.o_alu_a ^ seq_bus.o_alu_b);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    seq_bus.i_valid = 1'b1;
    seq_bus.i_data  = b;
    step();
    seq_bus.i_valid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a"},   32'(seq_bus.o_alu_a), 32'h0);
    chk({tag, "_b"},   32'(seq_bus.o_alu_b), 32'h0);
    chk({tag, "_op"},  32'(seq_bus.o_alu_op), 32'h0);
    chk({tag, "_res"}, 32'(seq_bus.o_result), 32'h0);
    chk({tag, "_rv"},  32'(seq_bus.o_result_valid), 32'h0);
    chk({tag, "_err"}, 32'(seq_bus.o_error), 32'h0);
  endtask

  initial begin
    seq_bus.i_data       = 8'h00;
    seq_bus.i_valid      = 1'b0;
    seq_bus.i_result_ack = 1'b0;

    // Reset state
    #2 rst = 1'b0;
    step();
    step();
    chk_all_zero("reset");
    chk("reset_ready", 32'(seq_bus.o_ready), 32'h1);
    rst = 1'b1;
    step();

    // 0x05 + 0x03 with op 0x20, back-to-back
    seq_bus.i_valid = 1'b1;
    seq_bus.i_data  = 8'h05;
    step();
    chk("t1_a", 32'(seq_bus.o_alu_a), 32'h05);
    chk("t1_ready_sb", 32'(seq_bus.o_ready), 32'h1);
    seq_bus.i_data = 8'h03;
    step();
    chk("t1_b", 32'(seq_bus.o_alu_b), 32'h03);
    seq_bus.i_data = 8'h20;
    step();
    seq_bus.i_valid = 1'b0;
    chk("t1_op", 32'(seq_bus.o_alu_op), 32'h20);
    chk("t1_exec_ready", 32'(seq_bus.o_ready), 32'h0);
    chk("t1_exec_rv", 32'(seq_bus.o_result_valid), 32'h0);
    step();
    chk("t1_rv", 32'(seq_bus.o_result_valid), 32'h1);
    chk("t1_result", 32'(seq_bus.o_result), 32'h08);
    chk("t1_hold_ready", 32'(seq_bus.o_ready), 32'h0);
    seq_bus.i_result_ack = 1'b1;
    step();
    seq_bus.i_result_ack = 1'b0;
    chk("t1_ack_rv", 32'(seq_bus.o_result_valid), 32'h0);
    chk("t1_ack_ready", 32'(seq_bus.o_ready), 32'h1);

    // Op byte 0xE0 keeps only the low six bits; then hold with i_valid asserted
    send(8'h10);
    send(8'h22);
    send(8'hE0);
    chk("t2_op", 32'(seq_bus.o_alu_op), 32'h20);
    seq_bus.i_valid = 1'b1;
    seq_bus.i_data  = 8'h55;
    step();
    chk("t2_result", 32'(seq_bus.o_result), 32'h32);
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t2_hold_ready", 32'(seq_bus.o_ready), 32'h0);
      chk("t2_hold_result", 32'(seq_bus.o_result), 32'h32);
    end
    chk("t2_hold_a", 32'(seq_bus.o_alu_a), 32'h10);
    chk("t2_hold_rv", 32'(seq_bus.o_result_valid), 32'h1);
    seq_bus.i_valid      = 1'b0;
    seq_bus.i_result_ack = 1'b1;
    step();
    seq_bus.i_result_ack = 1'b0;
    chk("t2_ack_ready", 32'(seq_bus.o_ready), 32'h1);
    chk("t2_ack_rv", 32'(seq_bus.o_result_valid), 32'h0);

    // Ack outside S_HOLD does nothing
    seq_bus.i_result_ack = 1'b1;
    step();
    seq_bus.i_result_ack = 1'b0;
    chk("t2_stray_ack_ready", 32'(seq_bus.o_ready), 32'h1);

    // Timeout after A: four idle cycles in S_B
    send(8'h11);
    chk("t3_a", 32'(seq_bus.o_alu_a), 32'h11);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_no_err_early", 32'(seq_bus.o_error), 32'h0);
    end
    step();
    chk("t3_err", 32'(seq_bus.o_error), 32'h1);
    chk("t3_err_ready", 32'(seq_bus.o_ready), 32'h1);
    chk("t3_b_kept", 32'(seq_bus.o_alu_b), 32'h22);
    chk("t3_result_kept", 32'(seq_bus.o_result), 32'h32);
    step();
    chk("t3_err_one_cycle", 32'(seq_bus.o_error), 32'h0);
    send(8'h77);
    chk("t3_next_is_a", 32'(seq_bus.o_alu_a), 32'h77);
    chk("t3_next_b_kept", 32'(seq_bus.o_alu_b), 32'h22);

    // Byte on the timeout cycle wins
    step();
    step();
    step();
    send(8'h09);
    chk("t4_b", 32'(seq_bus.o_alu_b), 32'h09);
    chk("t4_no_err", 32'(seq_bus.o_error), 32'h0);
    chk("t4_ready", 32'(seq_bus.o_ready), 32'h1);
    step();
    chk("t4_no_err_late", 32'(seq_bus.o_error), 32'h0);
    send(8'h20);
    step();
    chk("t4_result", 32'(seq_bus.o_result), 32'h80);
    chk("t4_rv", 32'(seq_bus.o_result_valid), 32'h1);
    seq_bus.i_result_ack = 1'b1;
    step();
    seq_bus.i_result_ack = 1'b0;

    // Reset during S_EXEC
    send(8'hAA);
    send(8'hBB);
    send(8'h20);
    chk("t5_exec_ready", 32'(seq_bus.o_ready), 32'h0);
    rst = 1'b0;
    #1;
    chk_all_zero("t5_async");
    chk("t5_async_ready", 32'(seq_bus.o_ready), 32'h1);
    step();
    chk("t5_in_reset_rv", 32'(seq_bus.o_result_valid), 32'h0);
    rst = 1'b1;
    step();
    chk("t5_post_err", 32'(seq_bus.o_error), 32'h0);
    send(8'h01);
    chk("t5_a", 32'(seq_bus.o_alu_a), 32'h01);
    send(8'h02);
    send(8'h20);
    step();
    chk("t5_result", 32'(seq_bus.o_result), 32'h03);
    chk("t5_rv", 32'(seq_bus.o_result_valid), 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL have parameter NB_DATA, default 8, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter NB_OP, default 6, giving the operation code width in bits.
REQ-003 The block SHALL have parameter TIMEOUT, default 255, giving the maximum idle cycles between bytes of one transaction.
REQ-004 The block SHALL have port i_clock, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port i_reset, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port i_data, input, NB_DATA bits: inbound byte (A, B or op).
REQ-007 The block SHALL have port i_valid, input, 1 bit: i_data is valid.
REQ-008 The block SHALL have port o_ready, output, 1 bit: the block accepts i_data this cycle.
REQ-009 The block SHALL have port o_alu_a, output, NB_DATA bits: registered operand A to the ALU.
REQ-010 The block SHALL have port o_alu_b, output, NB_DATA bits: registered operand B to the ALU.
REQ-011 The block SHALL have port o_alu_op, output, NB_OP bits: registered operation code to the ALU.
REQ-012 The block SHALL have port i_alu_result, input, NB_DATA bits: combinational ALU result.
REQ-013 The block SHALL have port o_result, output, NB_DATA bits: captured result.
REQ-014 The block SHALL have port o_result_valid, output, 1 bit: o_result is valid.
REQ-015 The block SHALL have port i_result_ack, input, 1 bit: the consumer takes the result.
REQ-016 The block SHALL have port o_error, output, 1 bit: one-cycle pulse on inter-byte timeout.

Function
REQ-017 A byte transfer SHALL occur on a rising edge where i_valid=1 and o_ready=1, and only then.
REQ-018 The FSM SHALL have states S_A, S_B, S_OP, S_EXEC and S_HOLD.
REQ-019 o_ready SHALL be 1 in S_A, S_B and S_OP, and 0 in S_EXEC and S_HOLD; o_ready SHALL NOT depend on i_valid.
REQ-020 S_A SHALL load o_alu_a from a transfer and then go to S_B; without a transfer it SHALL stay in S_A with no timeout.
REQ-021 S_B SHALL load o_alu_b from a transfer and then go to S_OP.
REQ-022 S_OP SHALL load o_alu_op from i_data[NB_OP-1:0] on a transfer, ignore the upper bits, and then go to S_EXEC.
REQ-023 S_EXEC SHALL last exactly one cycle; at its end the block SHALL register i_alu_result into o_result and go to S_HOLD.
REQ-024 o_result_valid SHALL be 1 exactly while in S_HOLD, so it is first high on the second cycle after the op transfer edge.
REQ-025 In S_HOLD, o_result SHALL stay stable and i_valid SHALL be ignored.
REQ-026 S_HOLD SHALL go to S_A on the first edge with i_result_ack=1.
REQ-027 i_result_ack outside S_HOLD SHALL have no effect.
REQ-028 o_alu_a, o_alu_b and o_alu_op SHALL hold their last loaded values in every state until reloaded.
REQ-029 The idle counter SHALL clear on entry to S_B or S_OP and on every transfer.
REQ-030 The idle counter SHALL increment on each cycle in S_B or S_OP without a transfer.
REQ-031 When the idle counter would reach TIMEOUT, the FSM SHALL go to S_A and o_error SHALL be 1 for exactly the next cycle.
REQ-032 A timeout SHALL leave operand and op registers unchanged and SHALL NOT change o_result.
REQ-033 If a transfer occurs on the same edge the timeout would fire, the transfer SHALL win and no error SHALL be raised.
REQ-034 The idle counter SHALL be wide enough to hold TIMEOUT without wrap-around, and it SHALL saturate, never wrap.
REQ-035 The block SHALL perform no arithmetic on data; widths SHALL pass through unchanged.
REQ-036 The block SHALL start a new transaction only after the previous one is acknowledged.

Reset
REQ-037 While i_reset=0, asynchronously and regardless of clock, the FSM SHALL be in S_A and o_alu_a, o_alu_b, o_alu_op, o_result, o_result_valid, o_error and the idle counter SHALL be 0.
REQ-038 Reset asserted mid-transaction, including in S_EXEC or S_HOLD, SHALL abort the transaction with no result and no error pulse.
REQ-039 After i_reset deasserts, the first transfer SHALL be treated as operand A.

Verification
REQ-040 The bench SHALL cover: bytes 0x05, 0x03, 0x20 back-to-back with a bench ALU computing A+B for op 0x20 -> o_alu_op=6'h20, o_result=0x08, o_result_valid high 2 cycles after the op edge.
REQ-041 The bench SHALL cover: op byte 0xE0 -> o_alu_op=6'h20, upper bits ignored.
REQ-042 The bench SHALL cover: TIMEOUT=4, A=0x11 then no byte for 4 cycles -> one-cycle o_error pulse, FSM in S_A, next byte loads o_alu_a.
REQ-043 The bench SHALL cover: a byte arriving exactly on the timeout cycle -> accepted, no o_error.
REQ-044 The bench SHALL cover: S_HOLD with i_valid=1 for 10 cycles and no ack -> o_ready=0, o_result stable; ack -> S_A next cycle.
REQ-045 The bench SHALL cover: i_reset=0 during S_EXEC -> all outputs 0 immediately; after release, bytes 0x01, 0x02, 0x20 -> o_result=0x03.
